// File: rtl/pinmux_pkg.sv
// Shared types, sizing helpers and default pad-assignment constants for the pinmux controller.
package pinmux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESP  = 2'd2
    } pinmux_state_e;

    function automatic int sel_w(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

    function automatic int pad_idx_w(input int npads);
        return (npads > 1) ? $clog2(npads) : 1;
    endfunction

    // Wide enough for any practical padring; the top truncates to its own widths.
    localparam int MaxPadIdxW = 16;
    localparam int MaxSelW    = 8;

    typedef struct packed {
        logic [MaxPadIdxW-1:0] pad;
        logic [MaxSelW-1:0]    sel;
    } pinmux_cfg_req_t;

    localparam int   DefaultNPads       = 64;
    localparam int   DefaultNSrc        = 4;
    localparam int   DefaultGuardCycles = 4;
    localparam logic DefaultInactiveIn  = 1'b1;
    localparam int   SrcGpio            = 0;

endpackage

// File: rtl/pinmux_pad_slice.sv
// One muxable pad: registered output/oe from the owning source, oe gating, and input fan-out.
module pinmux_pad_slice
    import pinmux_pkg::*;
#(
    parameter int   NSrc       = DefaultNSrc,
    parameter logic InactiveIn = DefaultInactiveIn,
    localparam int  SelW       = sel_w(NSrc)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [SelW-1:0] sel_i,
    input  logic            gate_i,
    input  logic [NSrc-1:0] periph_out_i,
    input  logic [NSrc-1:0] periph_oe_i,
    input  logic            pad_in_i,
    output logic [NSrc-1:0] periph_in_o,
    output logic            pad_out_o,
    output logic            pad_oe_o
);

    logic pad_out_d, pad_oe_d;
    logic pad_out_q, pad_oe_q;

    always_comb begin
        pad_out_d   = 1'b0;
        pad_oe_d    = 1'b0;
        periph_in_o = {NSrc{InactiveIn}};
        for (int s = 0; s < NSrc; s++) begin
            if (sel_i == SelW'(s)) begin
                pad_out_d      = periph_out_i[s];
                pad_oe_d       = periph_oe_i[s];
                periph_in_o[s] = gate_i ? InactiveIn : pad_in_i;
            end
        end
        pad_oe_d = pad_oe_d & ~gate_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pad_out_q <= 1'b0;
            pad_oe_q  <= 1'b0;
        end else begin
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
        end
    end

    assign pad_out_o = pad_out_q;
    assign pad_oe_o  = pad_oe_q;

endmodule

// File: rtl/pinmux_ctrl.sv
// Pinmux top: per-pad owner select with a break-before-make switch FSM and NPads pad slices.
// Optional: define PINMUX_CTRL_INPUT_SYNC_EN to pass pad_in_i through a 2-flop synchroniser.
module pinmux_ctrl
    import pinmux_pkg::*;
#(
    parameter int   NPads       = DefaultNPads,
    parameter int   NSrc        = DefaultNSrc,
    parameter int   GuardCycles = DefaultGuardCycles,
    parameter logic InactiveIn  = DefaultInactiveIn,
    localparam int  SelW        = sel_w(NSrc),
    localparam int  PadIdxW     = pad_idx_w(NPads)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NSrc*NPads-1:0] periph_out_i,
    input  logic [NSrc*NPads-1:0] periph_oe_i,
    output logic [NSrc*NPads-1:0] periph_in_o,
    output logic [NPads-1:0]      pad_out_o,
    output logic [NPads-1:0]      pad_oe_o,
    input  logic [NPads-1:0]      pad_in_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [PadIdxW-1:0]    cfg_pad_i,
    input  logic [SelW-1:0]       cfg_sel_i,
    input  logic                  cfg_lock_i,
    output logic                  cfg_rsp_valid_o,
    output logic                  cfg_err_o,
    output logic                  busy_o
);

    localparam int CntW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;

    pinmux_state_e   state_q;
    pinmux_cfg_req_t req_q;
    logic [SelW-1:0] sel_q [NPads];
    logic [CntW-1:0] cnt_q;
    logic            lock_q, ready_q, rsp_valid_q, err_q, busy_q;

    logic [SelW-1:0] cur_sel;
    logic            req_bad;
    logic [NPads-1:0] gate;
    logic [NPads-1:0] pad_in_rt;

    logic [NSrc-1:0] src_out [NPads];
    logic [NSrc-1:0] src_oe  [NPads];
    logic [NSrc-1:0] src_in  [NPads];

`ifdef PINMUX_CTRL_INPUT_SYNC_EN
    logic [NPads-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= {NPads{InactiveIn}};
            sync2_q <= {NPads{InactiveIn}};
        end else begin
            sync1_q <= pad_in_i;
            sync2_q <= sync1_q;
        end
    end

    assign pad_in_rt = sync2_q;
`else
    assign pad_in_rt = pad_in_i;
`endif

    // Out-of-range pad indices fall through to GPIO and are rejected by req_bad anyway.
    always_comb begin
        cur_sel = '0;
        for (int p = 0; p < NPads; p++) begin
            if (cfg_pad_i == PadIdxW'(p)) cur_sel = sel_q[p];
        end
    end

    assign req_bad = lock_q || (int'(cfg_sel_i) >= NSrc) || (int'(cfg_pad_i) >= NPads);

    always_comb begin
        gate = '0;
        for (int p = 0; p < NPads; p++) begin
            gate[p] = (state_q == ST_DRAIN) && (req_q.pad == MaxPadIdxW'(p));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            lock_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            for (int p = 0; p < NPads; p++) sel_q[p] <= SelW'(SrcGpio);
        end else begin
            lock_q      <= lock_q | cfg_lock_i;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_valid_i && ready_q) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (req_bad) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            err_q       <= 1'b1;
                        end else if (cfg_sel_i == cur_sel) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            err_q       <= 1'b0;
                        end else begin
                            state_q <= ST_DRAIN;
                            req_q   <= '{pad: MaxPadIdxW'(cfg_pad_i), sel: MaxSelW'(cfg_sel_i)};
                            cnt_q   <= CntW'(GuardCycles - 1);
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Pad stays tristated until the guard count expires, then changes hands.
                    if (cnt_q == '0) begin
                        for (int p = 0; p < NPads; p++) begin
                            if (req_q.pad == MaxPadIdxW'(p)) sel_q[p] <= req_q.sel[SelW-1:0];
                        end
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o     = ready_q;
    assign cfg_rsp_valid_o = rsp_valid_q;
    assign cfg_err_o       = err_q;
    assign busy_o          = busy_q;

    // Flat bus layout is source-major: bit s*NPads+p belongs to source s, pad p.
    always_comb begin
        for (int p = 0; p < NPads; p++) begin
            src_out[p] = '0;
            src_oe[p]  = '0;
            for (int s = 0; s < NSrc; s++) begin
                src_out[p][s] = periph_out_i[s*NPads+p];
                src_oe[p][s]  = periph_oe_i[s*NPads+p];
            end
        end
    end

    always_comb begin
        periph_in_o = '0;
        for (int p = 0; p < NPads; p++) begin
            for (int s = 0; s < NSrc; s++) begin
                periph_in_o[s*NPads+p] = src_in[p][s];
            end
        end
    end

    for (genvar p = 0; p < NPads; p++) begin : g_pad
        pinmux_pad_slice #(
            .NSrc       (NSrc),
            .InactiveIn (InactiveIn)
        ) u_slice (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .sel_i        (sel_q[p]),
            .gate_i       (gate[p]),
            .periph_out_i (src_out[p]),
            .periph_oe_i  (src_oe[p]),
            .pad_in_i     (pad_in_rt[p]),
            .periph_in_o  (src_in[p]),
            .pad_out_o    (pad_out_o[p]),
            .pad_oe_o     (pad_oe_o[p])
        );
    end

endmodule

// File: tb/tb_pinmux_ctrl.sv
// Directed bench for pinmux_ctrl with a response scoreboard (62 pads, 3 sources, guard of 4).
module tb_pinmux_ctrl;

    localparam int NPADS = 62;
    localparam int NSRC  = 3;
    localparam int GUARD = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [NSRC*NPADS-1:0] periph_out_i;
    logic [NSRC*NPADS-1:0] periph_oe_i;
    logic [NSRC*NPADS-1:0] periph_in_o;
    logic [NPADS-1:0]      pad_out_o;
    logic [NPADS-1:0]      pad_oe_o;
    logic [NPADS-1:0]      pad_in_i;
    logic                  cfg_valid_i;
    logic                  cfg_ready_o;
    logic [5:0]            cfg_pad_i;
    logic [1:0]            cfg_sel_i;
    logic                  cfg_lock_i;
    logic                  cfg_rsp_valid_o;
    logic                  cfg_err_o;
    logic                  busy_o;

    pinmux_ctrl #(
        .NPads       (NPADS),
        .NSrc        (NSRC),
        .GuardCycles (GUARD),
        .InactiveIn  (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .periph_out_i    (periph_out_i),
        .periph_oe_i     (periph_oe_i),
        .periph_in_o     (periph_in_o),
        .pad_out_o       (pad_out_o),
        .pad_oe_o        (pad_oe_o),
        .pad_in_i        (pad_in_i),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_pad_i       (cfg_pad_i),
        .cfg_sel_i       (cfg_sel_i),
        .cfg_lock_i      (cfg_lock_i),
        .cfg_rsp_valid_o (cfg_rsp_valid_o),
        .cfg_err_o       (cfg_err_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic err;
        int   lat;
    } resp_t;

    resp_t exp_q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    logic  oe_hist [32];
    bit    other_ok;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues one request; cycle n after the handshake edge T is observed as "cycle T+n".
    task automatic do_cfg(input int pad, input int sel, input logic exp_err, input int exp_lat,
                          input int lock_at, input int rst_at);
        int    n;
        bit    got;
        bit    stop;
        resp_t e;
        n = 0;
        while (cfg_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_req", cfg_ready_o, 1'b1);
        cfg_valid_i = 1'b1;
        cfg_pad_i   = 6'(pad);
        cfg_sel_i   = 2'(sel);
        tick();
        cfg_valid_i = 1'b0;
        if (rst_at < 0) exp_q.push_back('{err: exp_err, lat: exp_lat});
        got      = 1'b0;
        stop     = 1'b0;
        other_ok = 1'b1;
        for (n = 1; n < 32 && !got && !stop; n++) begin
            if (pad < NPADS) oe_hist[n] = pad_oe_o[pad];
            if (pad_oe_o[61] !== 1'b1 || pad_out_o[61] !== 1'b0) other_ok = 1'b0;
            if (cfg_rsp_valid_o === 1'b1) begin
                got = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_latency", 64'(n), 64'(e.lat));
                    check("rsp_err", cfg_err_o, e.err);
                end
            end else if (n == rst_at) begin
                rst_ni = 1'b0;
                stop   = 1'b1;
            end else begin
                cfg_lock_i = (n == lock_at);
                tick();
            end
        end
        cfg_lock_i = 1'b0;
        if (rst_at < 0 && !got) begin
            check("rsp_timeout", 1'b0, 1'b1);
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni       = 1'b0;
        periph_out_i = '0;
        periph_oe_i  = '0;
        pad_in_i     = '0;
        cfg_valid_i  = 1'b0;
        cfg_pad_i    = '0;
        cfg_sel_i    = '0;
        cfg_lock_i   = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_pad_oe", pad_oe_o, '0);
        check("rst_pad_out", pad_out_o, '0);
        check("rst_ready", cfg_ready_o, 1'b0);
        check("rst_rsp_valid", cfg_rsp_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_ni = 1'b1;
        tick();
        check("ready_after_rst", cfg_ready_o, 1'b1);

        // GPIO owns everything after reset
        periph_oe_i[0*NPADS+5] = 1'b1;
        tick();
        check("gpio_oe_pad5", pad_oe_o, 64'(1) << 5);
        check("inactive_in_s1_p5", periph_in_o[1*NPADS+5], 1'b1);
        check("gpio_in_s0_p5", periph_in_o[0*NPADS+5], 1'b0);

        // Switch pad 60 to source 2
        periph_oe_i  = '1;
        periph_out_i = {{(2*NPADS){1'b1}}, {NPADS{1'b0}}};
        tick();
        check("pre_switch_oe60", pad_oe_o[60], 1'b1);
        do_cfg(60, 2, 1'b0, GUARD + 1, -1, -1);
        check("switch_oe_t1", oe_hist[1], 1'b1);
        for (int n = 2; n <= GUARD + 1; n++) check("switch_oe_dip", oe_hist[n], 1'b0);
        check("switch_p61_stable", other_ok, 1'b1);
        tick();
        check("new_owner_oe60", pad_oe_o[60], 1'b1);
        check("new_owner_out60", pad_out_o[60], 1'b1);
        check("new_owner_in_s2", periph_in_o[2*NPADS+60], 1'b0);
        check("old_owner_in_s0", periph_in_o[0*NPADS+60], 1'b1);
        check("busy_after_switch", busy_o, 1'b0);

        // Same selection again: no drain
        do_cfg(60, 2, 1'b0, 1, -1, -1);
        check("noop_oe_t1", oe_hist[1], 1'b1);
        tick();
        check("noop_oe_after", pad_oe_o[60], 1'b1);

        // Invalid source and invalid pad
        do_cfg(7, 3, 1'b1, 1, -1, -1);
        tick();
        check("bad_sel_keeps_gpio", periph_in_o[0*NPADS+7], 1'b0);
        do_cfg(62, 1, 1'b1, 1, -1, -1);
        tick();

        // Lock during a drain: current switch completes, next is refused
        do_cfg(10, 1, 1'b0, GUARD + 1, 2, -1);
        tick();
        check("locked_switch_done", periph_in_o[1*NPADS+10], 1'b0);
        do_cfg(11, 1, 1'b1, 1, -1, -1);
        tick();
        check("locked_pad11_gpio", periph_in_o[0*NPADS+11], 1'b0);

        // Reset clears the lock
        rst_ni = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        check("pad60_back_gpio", periph_in_o[0*NPADS+60], 1'b0);
        do_cfg(11, 1, 1'b0, GUARD + 1, -1, -1);
        tick();
        check("unlock_switch_done", periph_in_o[1*NPADS+11], 1'b0);

        // Reset in the middle of a drain
        do_cfg(20, 2, 1'b0, GUARD + 1, -1, 3);
        tick();
        check("midrst_rsp", cfg_rsp_valid_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_ready", cfg_ready_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("midrst_ready_release", cfg_ready_o, 1'b1);
        check("midrst_no_rsp", cfg_rsp_valid_o, 1'b0);
        check("midrst_pad20_gpio", periph_in_o[0*NPADS+20], 1'b0);
        check("midrst_pad20_s2_idle", periph_in_o[2*NPADS+20], 1'b1);
        check("midrst_pad20_oe", pad_oe_o[20], 1'b1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
